ser_word_tx: RTL and testbench
==============================

Name: ser_word_tx

Overview:
- Upstream serializer feeding the serial deserializer stage.
- Accepts 16-bit feature words over a valid/ready word interface and shifts them out one bit per clock on `ser`, LSB first.
- Word order: data points 0..num_dp; within each data point, feature index feat down to 0.
- Used to stream a (num_dp+1) x (feat+1) dataset into the deserializer. Sits between the dataset memory/controller and the serial link.

Parameters:
- WORD_W, 16, bits per feature word.
- DP_W, 3, width of the num_dp field (last data-point index).
- FEAT_W, 5, width of the feat field (last feature index).

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE
- num_dp  input  DP_W  last data-point index; latched on accepted start
- feat  input  FEAT_W  last feature index; latched on accepted start
- word_data  input  WORD_W  next word to transmit
- word_valid  input  1  word_data valid
- word_ready  output  1  block accepts word_data this cycle
- ser  output  1  serial data bit
- ser_valid  output  1  ser carries a data bit this cycle
- busy  output  1  frame in progress (not IDLE)
- done  output  1  one-cycle pulse after the final bit of the frame
- dp_idx  output  DP_W  data-point index of the word being shifted
- feat_idx  output  FEAT_W  feature index of the word being shifted

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; shift register, counters and latched fields are 0.
  - Outputs: word_ready=0, ser=0, ser_valid=0, busy=0, done=0, dp_idx=0, feat_idx=0.
  - Reset mid-frame aborts the frame immediately. done is not pulsed. No partial word is resumed.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 latches num_dp and feat, sets dp_idx=0 and feat_idx=latched feat, then goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - word_ready=1.
  - On word_valid & word_ready: capture word_data into the shift register, clear bit_cnt, go to SHIFT.
  - Otherwise stay in LOAD with ser_valid=0. Stalls are unbounded.
- SHIFT:
  - ser = sreg[0] and ser_valid=1 every cycle. Shift right each cycle; bit_cnt increments.
  - The word occupies exactly WORD_W consecutive cycles.
  - Output is registered: the first bit appears the cycle after the word is accepted.
- Prefetch:
  - In the SHIFT cycle where bit_cnt=WORD_W-1 and the current word is not the last, word_ready=1.
  - If word_valid=1 in that cycle, the next word loads directly and SHIFT continues with no gap.
  - Otherwise go to LOAD. ser_valid is 0 for each gap cycle.
- Index advance at word end:
  - If feat_idx=0: set feat_idx=latched feat and increment dp_idx.
  - Otherwise decrement feat_idx.
- Last word: dp_idx=latched num_dp and feat_idx=0. After its final bit, go to DONE.
- DONE: done=1 for one cycle, busy=1, then return to IDLE.
  - start asserted during DONE is ignored; it is only accepted once back in IDLE.
- Totals:
  - Frame carries (num_dp+1)*(feat+1) words.
  - Minimum frame length: that word count times WORD_W ser_valid cycles, plus 1 LOAD cycle, plus 1 DONE cycle.
- Zero-size fields: num_dp=0 and feat=0 sends exactly one word.
- busy=1 in LOAD, SHIFT and DONE.
- word_ready is 0 in IDLE and DONE.
- ser holds 0 whenever ser_valid=0.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: each word is followed by one even-parity slot.
  - That slot carries ser = XOR of the word's WORD_W bits, with ser_valid=1.
  - Each word then occupies WORD_W+1 cycles.
  - Prefetch moves to the parity cycle.
- Undefined: no parity slot; exactly WORD_W cycles per word.

Test Plan:
- Reset, then start with num_dp=0, feat=0 and word 16'h8001 valid -> ser sequence 1,0,...,0,1 over 16 ser_valid cycles; then done pulses once, busy=0 the next cycle.
- num_dp=4, feat=11 with words always valid -> 60 words and 960 contiguous ser_valid cycles with no gap. (dp_idx,feat_idx) sequence runs (0,11),(0,10)...(0,0),(1,11)...(4,0). Exactly one done pulse.
- word_valid withheld 3 cycles before word 2 -> 3 cycles of ser_valid=0 with ser=0, then word 2 bits resume intact; total bit count unchanged.
- Assert RST low during bit 7 of word 3 -> all outputs 0 within the same cycle (asynchronous); no done. A new start after reset begins at dp_idx=0.
- Pulse start while busy, including in the DONE cycle -> ignored; the latched num_dp/feat are unchanged mid-frame.
- With SER_PARITY_EN, word 16'h0007 -> 16 data bits followed by a parity bit of 1, 17 ser_valid cycles per word.

Source files
------------

// File: rtl/ser_word_tx.sv
// Word-to-bit serializer: streams a (num_dp+1) x (feat+1) set of words LSB first on ser.
// Optional even-parity slot after each word when SER_PARITY_EN is defined.
module ser_word_tx #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned DP_W   = 3,
    parameter int unsigned FEAT_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DP_W-1:0]   num_dp,
    input  logic [FEAT_W-1:0] feat,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ser,
    output logic              ser_valid,
    output logic              busy,
    output logic              done,
    output logic [DP_W-1:0]   dp_idx,
    output logic [FEAT_W-1:0] feat_idx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

`ifdef SER_PARITY_EN
    localparam int unsigned SLOT_W = WORD_W + 1;
`else
    localparam int unsigned SLOT_W = WORD_W;
`endif
    localparam int unsigned      CNT_W    = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DP_W-1:0]   num_dp_q, num_dp_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic [DP_W-1:0]   dp_idx_q, dp_idx_d;
    logic [FEAT_W-1:0] feat_idx_q, feat_idx_d;
`ifdef SER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic last_word;
    logic word_end;
    logic accept;

    assign last_word = (dp_idx_q == num_dp_q) && (feat_idx_q == '0);
    assign word_end  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);

    // Prefetch: the next word is taken in the final slot of the current one.
    assign word_ready = (state_q == LOAD) || (word_end && !last_word);
    assign accept     = word_ready && word_valid;

    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dp_idx    = dp_idx_q;
    assign feat_idx  = feat_idx_q;

    always_comb begin
        ser = 1'b0;
        if (state_q == SHIFT) begin
`ifdef SER_PARITY_EN
            ser = (bit_cnt_q == LAST_BIT) ? parity_q : sreg_q[0];
`else
            ser = sreg_q[0];
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        num_dp_d   = num_dp_q;
        feat_d     = feat_q;
        dp_idx_d   = dp_idx_q;
        feat_idx_d = feat_idx_q;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_dp_d   = num_dp;
                    feat_d     = feat;
                    dp_idx_d   = '0;
                    feat_idx_d = feat;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    sreg_d    = word_data;
                    bit_cnt_d = '0;
`ifdef SER_PARITY_EN
                    parity_d  = ^word_data;
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d    = sreg_q >> 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (word_end) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        if (feat_idx_q == '0) begin
                            feat_idx_d = feat_q;
                            dp_idx_d   = dp_idx_q + DP_W'(1);
                        end else begin
                            feat_idx_d = feat_idx_q - FEAT_W'(1);
                        end
                        if (accept) begin
                            sreg_d    = word_data;
                            bit_cnt_d = '0;
`ifdef SER_PARITY_EN
                            parity_d  = ^word_data;
`endif
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            num_dp_q   <= '0;
            feat_q     <= '0;
            dp_idx_q   <= '0;
            feat_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            num_dp_q   <= num_dp_d;
            feat_q     <= feat_d;
            dp_idx_q   <= dp_idx_d;
            feat_idx_q <= feat_idx_d;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_ser_word_tx.sv
// Self-checking bench for ser_word_tx: table of frame scenarios plus reset/abort sequences.
`timescale 1ns/1ps
module tb_ser_word_tx;

    localparam int WORD_W = 16;
    localparam int DP_W   = 3;
    localparam int FEAT_W = 5;
`ifdef SER_PARITY_EN
    localparam int SLOT = WORD_W + 1;
`else
    localparam int SLOT = WORD_W;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              start = 1'b0;
    logic [DP_W-1:0]   num_dp = '0;
    logic [FEAT_W-1:0] feat = '0;
    logic [WORD_W-1:0] word_data = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              ser;
    logic              ser_valid;
    logic              busy;
    logic              done;
    logic [DP_W-1:0]   dp_idx;
    logic [FEAT_W-1:0] feat_idx;

    always #5 CLK = ~CLK;

    ser_word_tx #(
        .WORD_W(WORD_W),
        .DP_W  (DP_W),
        .FEAT_W(FEAT_W)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .num_dp    (num_dp),
        .feat      (feat),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .ser       (ser),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done),
        .dp_idx    (dp_idx),
        .feat_idx  (feat_idx)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int          ndp;
        int          f;
        logic [15:0] w0;
        int          stall_word;
        int          stall_len;
        bit          noise;
        bit          abort;
        int          exp_words;
        int          exp_idle;
    } vec_t;

    vec_t vecs [8];
    logic [WORD_W-1:0] wbuf [0:255];

    task automatic run_frame(input int k);
        vec_t  v;
        int    nxt, widx, bitpos, vcyc, idle, busyc, dones;
        int    bit_errs, idx_errs, zero_errs, stall_cnt, cyc;
        bit    hs, fin, aborted, after_done;
        logic  exp_bit;
        string tag;
        v = vecs[k];
        nxt = 0; widx = 0; bitpos = 0; vcyc = 0; idle = 0; busyc = 0; dones = 0;
        bit_errs = 0; idx_errs = 0; zero_errs = 0; stall_cnt = 0; cyc = 0;
        hs = 0; fin = 0; aborted = 0; after_done = 0;
        tag = $sformatf("v%0d", k);
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = 16'((i * 40503) ^ 50085 ^ (i << 11));
        end
        wbuf[0] = v.w0;

        @(negedge CLK);
        num_dp     = DP_W'(v.ndp);
        feat       = FEAT_W'(v.f);
        start      = 1'b1;
        word_valid = 1'b0;

        while (!fin && cyc < 20000) begin
            @(negedge CLK);
            if (hs) nxt++;
            if (after_done) begin
                chk({tag, " busy after done"}, busy, 0);
                chk({tag, " done one cycle"}, done, 0);
                fin = 1;
            end
            if (cyc == 0) begin
                chk({tag, " load busy"}, busy, 1);
                chk({tag, " load ready"}, word_ready, 1);
                chk({tag, " load dp_idx"}, dp_idx, 0);
                chk({tag, " load feat_idx"}, feat_idx, v.f);
            end
            if (busy) busyc++;
            if (done && !after_done) begin
                dones++;
                chk({tag, " ready in done"}, word_ready, 0);
                after_done = 1;
            end
            if (ser_valid) begin
                if (widx < 256) begin
                    if (bitpos == 0) begin
                        if (dp_idx != DP_W'(widx / (v.f + 1)) ||
                            feat_idx != FEAT_W'(v.f - widx % (v.f + 1)))
                            idx_errs++;
                    end
                    exp_bit = (bitpos < WORD_W) ? wbuf[widx][bitpos] : ^wbuf[widx];
                    if (ser !== exp_bit) bit_errs++;
                end else begin
                    bit_errs++;
                end
                vcyc++;
                if (v.abort && widx == 3 && bitpos == 7) begin
                    RST = 1'b0;
                    #1;
                    chk({tag, " abort ctl outputs"},
                        int'({word_ready, ser, ser_valid, busy, done}), 0);
                    chk({tag, " abort dp_idx"}, dp_idx, 0);
                    chk({tag, " abort feat_idx"}, feat_idx, 0);
                    repeat (2) @(negedge CLK);
                    RST = 1'b1;
                    word_valid = 1'b0;
                    repeat (3) begin
                        @(negedge CLK);
                        if (done) dones++;
                    end
                    chk({tag, " idle after abort"}, busy, 0);
                    aborted = 1;
                    fin = 1;
                end
                bitpos++;
                if (bitpos == SLOT) begin
                    bitpos = 0;
                    widx++;
                end
            end else begin
                if (ser !== 1'b0) zero_errs++;
                if (busy && !done) idle++;
            end
            if (!fin) begin
                start  = 1'b0;
                num_dp = DP_W'(v.ndp);
                feat   = FEAT_W'(v.f);
                if (v.noise && (cyc == 0 || cyc == 7 || cyc == 40 || done)) begin
                    start  = 1'b1;
                    num_dp = '1;
                    feat   = '1;
                end
                if (word_ready && nxt == v.stall_word && stall_cnt < v.stall_len) begin
                    word_valid = 1'b0;
                    stall_cnt++;
                end else begin
                    word_valid = 1'b1;
                end
                word_data = (nxt < 256) ? wbuf[nxt] : '0;
                hs = word_ready && word_valid;
            end
            cyc++;
        end
        start      = 1'b0;
        word_valid = 1'b0;
        num_dp     = DP_W'(v.ndp);
        feat       = FEAT_W'(v.f);

        if (!fin) chk({tag, " frame completed in budget"}, 0, 1);
        chk({tag, " bit errors"}, bit_errs, 0);
        chk({tag, " index errors"}, idx_errs, 0);
        chk({tag, " ser nonzero when invalid"}, zero_errs, 0);
        if (aborted) begin
            chk({tag, " no done on abort"}, dones, 0);
        end else begin
            chk({tag, " words sent"}, widx, v.exp_words);
            chk({tag, " partial word"}, bitpos, 0);
            chk({tag, " ser_valid cycles"}, vcyc, v.exp_words * SLOT);
            chk({tag, " gap cycles"}, idle, v.exp_idle);
            chk({tag, " busy cycles"}, busyc, v.exp_words * SLOT + v.exp_idle + 1);
            chk({tag, " done pulses"}, dones, 1);
        end
    endtask

    initial begin
        //          ndp f  w0        stall  len noise abort words idle
        vecs[0] = '{0, 0,  16'h8001, -1,    0,  1'b0, 1'b0, 1,    1};
        vecs[1] = '{4, 11, 16'h1234, -1,    0,  1'b0, 1'b0, 60,   1};
        vecs[2] = '{2, 3,  16'hA5C3, 2,     3,  1'b0, 1'b0, 12,   4};
        vecs[3] = '{4, 11, 16'h0F0F, -1,    0,  1'b0, 1'b1, 60,   1};
        vecs[4] = '{1, 2,  16'hFFFF, -1,    0,  1'b1, 1'b0, 6,    1};
        vecs[5] = '{7, 31, 16'h0001, -1,    0,  1'b0, 1'b0, 256,  1};
        vecs[6] = '{0, 0,  16'h0007, -1,    0,  1'b0, 1'b0, 1,    1};
        vecs[7] = '{3, 0,  16'h4000, 1,     1,  1'b0, 1'b0, 4,    2};

        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset word_ready", word_ready, 0);
        chk("reset ser", ser, 0);
        chk("reset ser_valid", ser_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dp_idx", dp_idx, 0);
        chk("reset feat_idx", feat_idx, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle after reset release", busy, 0);

        for (int k = 0; k < 8; k++) begin
            run_frame(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
